request_unit: RTL and testbench

REQUEST_UNIT -- requirements
Module: request_unit

---
 rtl/cpu_types_pkg.sv | 11 +
 rtl/request_unit_if.sv | 29 ++
 rtl/request_unit.sv | 100 ++++++++++
 tb/tb_request_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU control types; request_unit FSM state encoding.
// Pure types, no logic, no latency.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } reqstate_t;

endpackage

// File: rtl/request_unit_if.sv
// Control-unit/memory side signals of request_unit, one modport per side.
// No logic; the ru side drives requests, the tb side drives hits and decodes.
interface request_unit_if;

  logic        iREN;
  logic        dREN;
  logic        dWEN;
  logic        halt;
  logic        ihit;
  logic        dhit;
  logic        imemREN;
  logic        dmemREN;
  logic        dmemWEN;
  logic        pc_en;
  logic        halted;
  logic        mem_err;
  logic [31:0] retired;

  modport ru (
    input  iREN, dREN, dWEN, halt, ihit, dhit,
    output imemREN, dmemREN, dmemWEN, pc_en, halted, mem_err, retired
  );

  modport tb (
    output iREN, dREN, dWEN, halt, ihit, dhit,
    input  imemREN, dmemREN, dmemWEN, pc_en, halted, mem_err, retired
  );

endinterface

// File: rtl/request_unit.sv
// Sequences instruction fetch then optional data access; pc_en pulses in the hit cycle.
// Memory stalls by withholding ihit/dhit; a data wait beyond WAIT_LIMIT faults and halts.
module request_unit
  import cpu_types_pkg::*;
#(
  parameter logic [7:0] WAIT_LIMIT = 8'd255
) (
  input  logic           CLK,
  input  logic           RST,
  request_unit_if.ru     ruif
);

  reqstate_t   state, state_n;
  logic        dren_q, dren_n;
  logic        dwen_q, dwen_n;
  logic [7:0]  wait_q, wait_n;
  logic        err_q, err_n;
  logic [31:0] retired_q;
  logic        rst_q;
  logic        imem_ren, dmem_ren, dmem_wen, pc_en;

  always_comb begin
    state_n  = state;
    dren_n   = dren_q;
    dwen_n   = dwen_q;
    wait_n   = wait_q;
    err_n    = err_q;
    imem_ren = 1'b0;
    dmem_ren = 1'b0;
    dmem_wen = 1'b0;
    pc_en    = 1'b0;
    case (state)
      FETCH: begin
        imem_ren = ruif.iREN;
        // A hit seen right after reset belongs to the aborted request.
        if (ruif.ihit && !rst_q) begin
          if (ruif.halt) begin
            state_n = HALTED;
          end else if (ruif.dREN || ruif.dWEN) begin
            state_n = DATA;
            dren_n  = ruif.dREN;
            dwen_n  = ruif.dWEN;
            wait_n  = 8'd0;
          end else begin
            pc_en = 1'b1;
          end
        end
      end
      DATA: begin
        dmem_ren = dren_q;
        dmem_wen = dwen_q;
        if (ruif.dhit) begin
          pc_en   = 1'b1;
          dren_n  = 1'b0;
          dwen_n  = 1'b0;
          state_n = FETCH;
        end else if (wait_q == WAIT_LIMIT) begin
          err_n   = 1'b1;
          dren_n  = 1'b0;
          dwen_n  = 1'b0;
          state_n = HALTED;
        end else begin
          wait_n = wait_q + 8'd1;
        end
      end
      HALTED: ;
      default: state_n = FETCH;
    endcase
    if (RST) pc_en = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= FETCH;
      dren_q    <= 1'b0;
      dwen_q    <= 1'b0;
      wait_q    <= 8'd0;
      err_q     <= 1'b0;
      retired_q <= 32'd0;
      rst_q     <= 1'b1;
    end else begin
      state  <= state_n;
      dren_q <= dren_n;
      dwen_q <= dwen_n;
      wait_q <= wait_n;
      err_q  <= err_n;
      rst_q  <= 1'b0;
      if (pc_en) retired_q <= retired_q + 32'd1;
    end
  end

  assign ruif.imemREN = imem_ren;
  assign ruif.dmemREN = dmem_ren;
  assign ruif.dmemWEN = dmem_wen;
  assign ruif.pc_en   = pc_en;
  assign ruif.halted  = (state == HALTED);
  assign ruif.mem_err = err_q;
  assign ruif.retired = retired_q;

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit; completions are predicted into a queue and
// consumed by a monitor whenever pc_en is seen.
module tb_request_unit;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  request_unit_if ruif ();

  request_unit #(.WAIT_LIMIT(8'd255)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .ruif (ruif)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_ret = 32'd0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_val = 32'd0;
  logic        pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic expect_completion();
    model_ret = model_ret + 32'd1;
    exp_q.push_back(model_ret);
  endtask

  // Every pc_en must match a predicted completion; retired is checked one cycle later.
  always @(negedge CLK) begin
    if (pend) begin
      chk("retired_after_pc_en", ruif.retired, pend_val);
      pend = 1'b0;
    end
    if (ruif.pc_en === 1'b1) begin
      chk("pc_en_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        pend_val = exp_q.pop_front();
        pend     = 1'b1;
      end
    end
  end

  task automatic clear_inputs();
    ruif.iREN = 1'b0;
    ruif.dREN = 1'b0;
    ruif.dWEN = 1'b0;
    ruif.halt = 1'b0;
    ruif.ihit = 1'b0;
    ruif.dhit = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    clear_inputs();
    model_ret = 32'd0;
    cyc();
  endtask

  initial begin
    int bad;
    clear_inputs();
    RST = 1'b1;
    cyc();
    cyc();
    mid();
    chk("rst_halted", ruif.halted, 0);
    chk("rst_mem_err", ruif.mem_err, 0);
    chk("rst_retired", ruif.retired, 0);
    chk("rst_pc_en", ruif.pc_en, 0);
    chk("rst_dmemREN", ruif.dmemREN, 0);

    // Cycle after reset: a stale ihit must not complete anything.
    cyc();
    RST = 1'b0;
    ruif.iREN = 1'b1;
    ruif.ihit = 1'b1;
    mid();
    chk("post_rst_pc_en", ruif.pc_en, 0);
    chk("post_rst_imemREN", ruif.imemREN, 1);
    cyc();

    // ALU instruction
    expect_completion();
    mid();
    chk("alu_pc_en", ruif.pc_en, 1);
    cyc();
    ruif.ihit = 1'b0;
    mid();
    chk("alu_retired", ruif.retired, 1);
    chk("fetch_idle_pc_en", ruif.pc_en, 0);
    cyc();

    // Load with dhit after 3 wait cycles; dREN dropped mid-wait
    ruif.ihit = 1'b1;
    ruif.dREN = 1'b1;
    ruif.dhit = 1'b1;
    mid();
    chk("ld_fetch_pc_en", ruif.pc_en, 0);
    chk("ld_fetch_dmemREN", ruif.dmemREN, 0);
    cyc();
    ruif.ihit = 1'b0;
    ruif.dhit = 1'b0;
    mid();
    chk("ld_w1_dmemREN", ruif.dmemREN, 1);
    chk("ld_w1_imemREN", ruif.imemREN, 0);
    cyc();
    ruif.dREN = 1'b0;
    mid();
    chk("ld_w2_dmemREN", ruif.dmemREN, 1);
    chk("ld_w2_dmemWEN", ruif.dmemWEN, 0);
    cyc();
    mid();
    chk("ld_w3_dmemREN", ruif.dmemREN, 1);
    cyc();
    ruif.dhit = 1'b1;
    expect_completion();
    mid();
    chk("ld_hit_dmemREN", ruif.dmemREN, 1);
    chk("ld_hit_pc_en", ruif.pc_en, 1);
    cyc();
    ruif.dhit = 1'b0;
    mid();
    chk("ld_done_dmemREN", ruif.dmemREN, 0);
    chk("ld_done_retired", ruif.retired, 2);
    cyc();

    // Halt wins over a store decoded in the same instruction
    ruif.ihit = 1'b1;
    ruif.halt = 1'b1;
    ruif.dWEN = 1'b1;
    mid();
    chk("halt_pc_en", ruif.pc_en, 0);
    chk("halt_dmemWEN", ruif.dmemWEN, 0);
    cyc();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      ruif.ihit = 1'($urandom_range(0, 1));
      ruif.dhit = 1'($urandom_range(0, 1));
      ruif.dREN = 1'($urandom_range(0, 1));
      ruif.dWEN = 1'($urandom_range(0, 1));
      ruif.halt = 1'($urandom_range(0, 1));
      mid();
      if (ruif.halted !== 1'b1 || ruif.dmemWEN !== 1'b0 || ruif.dmemREN !== 1'b0 ||
          ruif.imemREN !== 1'b0 || ruif.pc_en !== 1'b0) bad++;
      cyc();
    end
    chk("halt_hold_bad_cycles", bad, 0);
    chk("halt_retired", ruif.retired, 2);

    // Reset out of HALTED
    do_reset();
    mid();
    chk("rst_halt_halted", ruif.halted, 0);
    chk("rst_halt_retired", ruif.retired, 0);
    cyc();

    // Store timeout: 256 DATA cycles without dhit
    ruif.iREN = 1'b1;
    ruif.ihit = 1'b1;
    ruif.dWEN = 1'b1;
    cyc();
    clear_inputs();
    bad = 0;
    repeat (255) begin
      mid();
      if (ruif.dmemWEN !== 1'b1 || ruif.mem_err !== 1'b0 || ruif.halted !== 1'b0) bad++;
      cyc();
    end
    chk("to_wait_bad_cycles", bad, 0);
    mid();
    chk("to_last_dmemWEN", ruif.dmemWEN, 1);
    chk("to_last_mem_err", ruif.mem_err, 0);
    cyc();
    mid();
    chk("to_mem_err", ruif.mem_err, 1);
    chk("to_halted", ruif.halted, 1);
    chk("to_dmemWEN", ruif.dmemWEN, 0);
    cyc();

    // Same store, dhit on the 256th DATA cycle completes normally
    do_reset();
    ruif.iREN = 1'b1;
    ruif.ihit = 1'b1;
    ruif.dWEN = 1'b1;
    cyc();
    clear_inputs();
    repeat (255) cyc();
    ruif.dhit = 1'b1;
    expect_completion();
    mid();
    chk("edge_pc_en", ruif.pc_en, 1);
    cyc();
    ruif.dhit = 1'b0;
    mid();
    chk("edge_mem_err", ruif.mem_err, 0);
    chk("edge_halted", ruif.halted, 0);
    chk("edge_retired", ruif.retired, 1);
    cyc();

    // Reset in the middle of a load wait, with dhit arriving in the reset cycle
    ruif.iREN = 1'b1;
    ruif.ihit = 1'b1;
    ruif.dREN = 1'b1;
    cyc();
    ruif.ihit = 1'b0;
    cyc();
    cyc();
    RST = 1'b1;
    ruif.dhit = 1'b1;
    mid();
    chk("rst_data_pc_en", ruif.pc_en, 0);
    cyc();
    RST = 1'b0;
    ruif.dhit = 1'b0;
    ruif.dREN = 1'b0;
    model_ret = 32'd0;
    mid();
    chk("rst_data_dmemREN", ruif.dmemREN, 0);
    chk("rst_data_retired", ruif.retired, 0);
    chk("rst_data_pc_en_after", ruif.pc_en, 0);
    chk("rst_data_fetch_imemREN", ruif.imemREN, 1);
    cyc();

    // retired wrap via backdoor
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    model_ret = 32'hFFFF_FFFF;
    ruif.ihit = 1'b1;
    expect_completion();
    mid();
    chk("wrap_pc_en", ruif.pc_en, 1);
    cyc();
    ruif.ihit = 1'b0;
    mid();
    chk("wrap_retired", ruif.retired, 32'd0);
    cyc();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
